// File: rtl/sub3_pipe_pkg.sv
// Shared types and defaults for the three-operand subtractor pipeline.
package sub3_pipe_pkg;

   localparam int W_DEF     = 4;
   localparam int CNT_W_DEF = 8;

   // Operand bundle at the default width.
   typedef struct packed {
      logic [W_DEF-1:0] x;
      logic [W_DEF-1:0] y;
      logic [W_DEF-1:0] z;
      logic             cond;
   } operand_t;

   // Result bundle at the default width.
   typedef struct packed {
      logic [W_DEF-1:0] out;
      logic             borrow;
   } result_t;

endpackage

// File: rtl/sub3_pipe_sub.sv
// Two-operand combinational subtractor, r = a - b truncated to W bits.
module sub3_pipe_sub #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] r
);

   // Plain modular difference; the borrow out is not needed by the chain.
   assign r = a - b;

endmodule

// File: rtl/sub3_pipe.sv
// Two-stage valid/ready pipeline computing x - y - z mod 2^W with an
// underflow flag. Two arithmetically identical paths are built and compared
// every time stage 2 loads; a difference latches the sticky mismatch flag.
module sub3_pipe
   import sub3_pipe_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     x,
   input  logic [W-1:0]     y,
   input  logic [W-1:0]     z,
   input  logic             cond,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out,
   output logic             borrow,
   output logic             mismatch,
   output logic [CNT_W-1:0] cnt
);

   logic         s1_valid;
   logic [W-1:0] s1_x;
   logic [W-1:0] s1_y;
   logic [W-1:0] s1_z;
   logic         s1_cond;

   logic         s2_adv;
   logic         accept;
   logic         fire;

   logic [W-1:0] diff_xy;
   logic [W-1:0] chained;
   logic [W-1:0] direct;
   logic [W+1:0] wide;
   logic         borrow_d;

   assign s2_adv   = s1_valid && (!out_valid || out_ready);
   // No skid buffer: stage 1 frees up in the same cycle stage 2 drains.
   assign in_ready = !s1_valid || s2_adv;
   assign accept   = in_valid && in_ready;
   assign fire     = out_valid && out_ready;

   sub3_pipe_sub #(.W(W)) u_sub_xy (
      .a (s1_x),
      .b (s1_y),
      .r (diff_xy)
   );

   sub3_pipe_sub #(.W(W)) u_sub_z (
      .a (diff_xy),
      .b (s1_z),
      .r (chained)
   );

   assign direct = s1_x - s1_y - s1_z;

   // Two guard bits hold the sign of x - y - z even when y + z overflows W bits.
   assign wide     = {2'b00, s1_x} - {2'b00, s1_y} - {2'b00, s1_z};
   assign borrow_d = wide[W+1];

   // Stage 1: operand register, emptied when its contents move to stage 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_z     <= '0;
         s1_cond  <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_x     <= x;
         s1_y     <= y;
         s1_z     <= z;
         s1_cond  <= cond;
      end else if (s2_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: result register, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out       <= '0;
         borrow    <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= 1'b1;
         out       <= s1_cond ? chained : direct;
         borrow    <= borrow_d;
      end else if (fire) begin
         out_valid <= 1'b0;
      end
   end

   // Sticky cross-check of the two result paths, sampled as stage 2 loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch <= 1'b0;
      end else if (s2_adv && (chained != direct)) begin
         mismatch <= 1'b1;
      end
   end

   // Delivered-result counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (fire) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule
